return_stack: RTL and testbench
===============================

RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, address width matching the program counter.
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  call request; store return address this cycle.
REQ-006 SHALL have port pop  input  1  return request; emit top entry to program counter.
REQ-007 SHALL have port pc_in  input  WIDTH  current program-counter value at the call instruction.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port ret_addr  output  WIDTH  return address; drives the counter's parallel-load data.
REQ-010 SHALL have port load  output  1  one-cycle pulse; drives the counter's parallel-load select.
REQ-011 SHALL have port depth  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-012 SHALL have ports empty and full  output  1 each  depth==0 and depth==DEPTH, combinational from depth.
REQ-013 SHALL have ports overflow and underflow  output  1 each  sticky error flags.

Function
REQ-014 Push accepted (not full) SHALL write (pc_in + 1) mod 2^WIDTH at index depth and increment depth; pc_in=8'hFF stores 8'h00.
REQ-015 Pop accepted (not empty) SHALL register entry[depth-1] into ret_addr, assert load for exactly the next cycle, and decrement depth.
REQ-016 ret_addr SHALL hold its last value when load is low; load SHALL be low in every cycle without an accepted pop.
REQ-017 Latency: push visible in depth 1 cycle after the edge; pop produces ret_addr/load 1 cycle after the edge.
REQ-018 Push when full SHALL be dropped: no write, depth unchanged, overflow set next cycle.
REQ-019 Pop when empty SHALL be dropped: load stays low, ret_addr unchanged, underflow set next cycle.
REQ-020 Push and pop in the same cycle, not empty: ret_addr = old top, load pulses, the top slot is overwritten with the new return address, and depth is unchanged (full does not block this case).
REQ-021 Push and pop in the same cycle, empty: underflow set, push proceeds normally, depth becomes 1.
REQ-022 Overflow and underflow SHALL stay set until clr_err; clr_err has lower priority than a same-cycle new error, so the flag stays 1.
REQ-023 Entries above depth SHALL be don't-care; no read ever returns them.

Reset
REQ-024 reset_n low SHALL immediately force depth=0, ret_addr=0, load=0, overflow=0, underflow=0, independent of clk.
REQ-025 Reset during a pending load pulse SHALL kill the pulse; storage contents need not be reset.
REQ-026 After reset_n deasserts, the first rising edge SHALL process push/pop normally.

Structure
REQ-027 return_stack_pkg SHALL hold the WIDTH/DEPTH defaults and the depth/pointer typedef shared with the counter and the control unit.
REQ-028 Storage SHALL be one sub-module, lifo_mem: a synchronous-write, combinational-read array with no reset; pointer, flag, and load logic stay in return_stack.

Verification
REQ-029 Reset, then push pc_in=8'h10, 8'h20, 8'h30, then three pops -> ret_addr 8'h31, 8'h21, 8'h11 with one load pulse each, depth 3->0, empty=1.
REQ-030 Nine pushes with DEPTH=8 -> full=1 after the 8th, overflow=1 after the 9th, then 8 pops return the first 8 addresses in LIFO order.
REQ-031 Pop on empty -> load=0, ret_addr unchanged, underflow=1; clr_err -> underflow=0 next cycle; clr_err with a same-cycle bad pop -> underflow stays 1.
REQ-032 Depth 2 with top 8'h41, then push pc_in=8'h7F and pop together -> ret_addr=8'h41, load=1, depth=2; next pop -> ret_addr=8'h80.
REQ-033 Push pc_in=8'hFF -> pop returns 8'h00.
REQ-034 Assert reset_n low mid-cycle between a pop edge and the load cycle -> load=0, depth=0, flags=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/return_stack_pkg.sv
// return_stack_pkg: shared defaults and types for the return-address stack.
//   DefWidth - default return-address width (matches the program counter)
//   DefDepth - default number of stack entries (power of two, >= 2)
//   addr_t   - return address at default width
//   depth_t  - entry count 0..DefDepth
//   ptr_t    - entry index 0..DefDepth-1
package return_stack_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 8;

    typedef logic [DefWidth-1:0]           addr_t;
    typedef logic [$clog2(DefDepth):0]     depth_t;
    typedef logic [$clog2(DefDepth)-1:0]   ptr_t;

endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: storage array for the return stack.
// Synchronous write, combinational read, no reset (contents above the
// live depth are never read, so they need no defined value).
//   clk_i   - write clock
//   we_i    - write enable
//   waddr_i - write index
//   wdata_i - write data
//   raddr_i - read index
//   rdata_o - read data (combinational)
module lifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/return_stack.sv
// return_stack: hardware call/return address stack.
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   push      - call: store pc_in + 1
//   pop       - return: emit top entry on ret_addr with a load pulse
//   pc_in     - program counter at the call instruction
//   clr_err   - clears sticky overflow/underflow
//   ret_addr  - registered return address (held while load is low)
//   load      - one-cycle parallel-load strobe for the program counter
//   depth     - current entry count
//   empty     - depth == 0
//   full      - depth == DEPTH
//   overflow  - sticky: push dropped because full
//   underflow - sticky: pop dropped because empty
module return_stack
    import return_stack_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       pc_in,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       ret_addr,
    output logic                   load,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthOne  = (PtrW + 1)'(1);
    localparam logic [PtrW:0] DepthFull = (PtrW + 1)'(DEPTH);

    logic [PtrW:0]      depth_q, depth_d;
    logic [WIDTH-1:0]   ret_addr_q, ret_addr_d;
    logic               load_q, load_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               pop_ok, push_ok;
    logic [PtrW-1:0]    top_idx, wr_idx;
    logic [WIDTH-1:0]   rd_data, wr_data;

    assign empty = (depth_q == '0);
    assign full  = (depth_q == DepthFull);

    assign pop_ok  = pop && !empty;
    // A simultaneous accepted pop frees the top slot, so full does not block the push.
    assign push_ok = push && (!full || pop_ok);

    assign top_idx = PtrW'(depth_q - DepthOne);
    // Push+pop replaces the top entry in place; a lone push appends above it.
    assign wr_idx  = pop_ok ? top_idx : depth_q[PtrW-1:0];
    assign wr_data = pc_in + WIDTH'(1);

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo_mem (
        .clk_i   (clk),
        .we_i    (push_ok),
        .waddr_i (wr_idx),
        .wdata_i (wr_data),
        .raddr_i (top_idx),
        .rdata_o (rd_data)
    );

    always_comb begin
        depth_d = depth_q;
        if (push_ok && !pop_ok) begin
            depth_d = depth_q + DepthOne;
        end else if (pop_ok && !push_ok) begin
            depth_d = depth_q - DepthOne;
        end

        ret_addr_d = pop_ok ? rd_data : ret_addr_q;
        load_d     = pop_ok;

        // A new error in the same cycle wins over clr_err.
        overflow_d  = (push && !push_ok) || (overflow_q && !clr_err);
        underflow_d = (pop && !pop_ok) || (underflow_q && !clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q     <= '0;
            ret_addr_q  <= '0;
            load_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            ret_addr_q  <= ret_addr_d;
            load_q      <= load_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign depth     = depth_q;
    assign ret_addr  = ret_addr_q;
    assign load      = load_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: directed and randomized checks of return_stack against a
// queue-based reference model.
module tb_return_stack;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;

    logic             clk;
    logic             reset_n;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] pc_in;
    logic             clr_err;
    logic [WIDTH-1:0] ret_addr;
    logic             load;
    logic [3:0]       depth;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_ret;
    logic             exp_load;
    logic             exp_ovf;
    logic             exp_unf;

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .pc_in     (pc_in),
        .clr_err   (clr_err),
        .ret_addr  (ret_addr),
        .load      (load),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        exp_ret  = '0;
        exp_load = 1'b0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic p, input logic o, input logic [WIDTH-1:0] pc,
                         input logic c);
        logic pop_acc, push_acc;
        push = p; pop = o; pc_in = pc; clr_err = c;
        @(posedge clk);
        pop_acc  = o && (mq.size() > 0);
        push_acc = p && ((mq.size() < DEPTH) || pop_acc);
        exp_load = pop_acc;
        if (pop_acc) begin
            exp_ret = mq[$];
            void'(mq.pop_back());
        end
        if (push_acc) mq.push_back(pc + 8'd1);
        exp_ovf = (p && !push_acc) ? 1'b1 : (c ? 1'b0 : exp_ovf);
        exp_unf = (o && !pop_acc) ? 1'b1 : (c ? 1'b0 : exp_unf);
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; pc_in = '0;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got %h want 0", depth); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_tests++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b want 0", load); end
        n_tests++; if (ret_addr !== 8'h00) begin n_fail++; $display("FAIL reset_ret got %h want 00", ret_addr); end
        n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_basic();
        logic [7:0] want [3];
        want[0] = 8'h31; want[1] = 8'h21; want[2] = 8'h11;
        do_reset();
        cycle(1'b1, 1'b0, 8'h10, 1'b0);
        cycle(1'b1, 1'b0, 8'h20, 1'b0);
        cycle(1'b1, 1'b0, 8'h30, 1'b0);
        n_tests++; if (depth !== 4'd3) begin n_fail++; $display("FAIL basic_depth got %0d want 3", depth); end
        n_tests++; if (load !== 1'b0) begin n_fail++; $display("FAIL basic_noload got %b want 0", load); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            n_tests++; if (ret_addr !== want[i] || load !== 1'b1) begin
                n_fail++; $display("FAIL basic_pop%0d got %h/%b want %h/1", i, ret_addr, load, want[i]);
            end
            n_tests++; if (depth !== 4'(2 - i)) begin n_fail++; $display("FAIL basic_pdepth%0d got %0d want %0d", i, depth, 2 - i); end
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_tests++; if (load !== 1'b0 || ret_addr !== 8'h11) begin n_fail++; $display("FAIL basic_hold got %h/%b want 11/0", ret_addr, load); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h50 + 8'(i * 3)), 1'b0);
            if (i == 7) begin
                n_tests++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full got %b/%b want 1/0", full, overflow); end
            end
        end
        n_tests++; if (overflow !== 1'b1 || depth !== 4'd8) begin n_fail++; $display("FAIL ovf_flag got %b/%0d want 1/8", overflow, depth); end
        for (int i = 7; i >= 0; i--) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            n_tests++; if (ret_addr !== 8'(8'h51 + 8'(i * 3)) || load !== 1'b1) begin
                n_fail++; $display("FAIL ovf_pop%0d got %h/%b want %h/1", i, ret_addr, load, 8'(8'h51 + 8'(i * 3)));
            end
        end
        n_tests++; if (empty !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_end got %b/%b want 1/1", empty, overflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b1, 1'b0, 8'h20, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_tests++; if (load !== 1'b0 || ret_addr !== 8'h21 || underflow !== 1'b1) begin
            n_fail++; $display("FAIL unf_pop got %b/%h/%b want 0/21/1", load, ret_addr, underflow);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr got %b want 0", underflow); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_prio got %b want 1", underflow); end
        // Push and pop together on empty: pop dropped, push proceeds
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'h66, 1'b0);
        n_tests++; if (underflow !== 1'b1 || depth !== 4'd1 || load !== 1'b0) begin
            n_fail++; $display("FAIL unf_pushpop got %b/%0d/%b want 1/1/0", underflow, depth, load);
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        cycle(1'b1, 1'b0, 8'h10, 1'b0);
        cycle(1'b1, 1'b0, 8'h40, 1'b0);
        cycle(1'b1, 1'b1, 8'h7F, 1'b0);
        n_tests++; if (ret_addr !== 8'h41 || load !== 1'b1 || depth !== 4'd2) begin
            n_fail++; $display("FAIL pp_swap got %h/%b/%0d want 41/1/2", ret_addr, load, depth);
        end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_tests++; if (ret_addr !== 8'h80) begin n_fail++; $display("FAIL pp_next got %h want 80", ret_addr); end
        // Wraparound of pc_in + 1
        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_tests++; if (ret_addr !== 8'h00 || load !== 1'b1) begin n_fail++; $display("FAIL wrap got %h/%b want 00/1", ret_addr, load); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h55, 1'b0);
        cycle(1'b1, 1'b0, 8'h56, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_tests++; if (load !== 1'b1 || underflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %b/%b want 1/1", load, underflow); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (load !== 1'b0 || depth !== 4'd0 || underflow !== 1'b0 || overflow !== 1'b0 || ret_addr !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset got load=%b depth=%0d flags=%b%b ret=%h want 0/0/00/00",
                               load, depth, overflow, underflow, ret_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h09, 1'b0);
        n_tests++; if (depth !== 4'd1) begin n_fail++; $display("FAIL mid_after got %0d want 1", depth); end
    endtask

    task automatic test_random();
        int bias;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 40) % 2 == 0) ? 75 : 25;
            cycle(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) >= bias),
                  8'($urandom), 1'($urandom_range(0, 15) == 0));
            n_tests++;
            if (depth !== 4'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)
                || load !== exp_load || ret_addr !== exp_ret || overflow !== exp_ovf || underflow !== exp_unf) begin
                n_fail++;
                $display("FAIL rand%0d got d=%0d e=%b f=%b l=%b r=%h o=%b u=%b want d=%0d l=%b r=%h o=%b u=%b",
                         i, depth, empty, full, load, ret_addr, overflow, underflow,
                         mq.size(), exp_load, exp_ret, exp_ovf, exp_unf);
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; pc_in = '0;
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
